fifo_sync_vr: RTL and testbench
===============================

# fifo_sync_vr

Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides. It is the buffering stage that feeds the plain pipeline registers. It decouples a producer from a consumer that may stall, so the downstream register stage sees a clean valid/data stream. Storage, pointers and the occupancy count are flops in one clock domain.

## Interface
- DATA_WIDTH, 32, payload width in bits
- FIFO_DEPTH, 4, number of entries; power of two, at least 2
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  reset, asynchronous and active-low; clears all state immediately
- i_flush  in  1  synchronous flush; empties the FIFO on the next rising edge
- i_valid  in  1  upstream data valid
- o_ready  out  1  FIFO can accept data; equals !o_full
- i_data  in  DATA_WIDTH  upstream payload
- o_valid  out  1  head entry valid; equals !o_empty
- i_ready  in  1  downstream accepts the head entry
- o_data  out  DATA_WIDTH  head entry payload, driven from storage (no combinational path from i_data)
- o_count  out  $clog2(FIFO_DEPTH)+1  current occupancy, range 0..FIFO_DEPTH
- o_full  out  1  o_count == FIFO_DEPTH
- o_empty  out  1  o_count == 0

## Operation
- Push: i_valid && o_ready at the clock edge. i_data is written to mem[wr_ptr] and wr_ptr increments.
- Pop: o_valid && i_ready at the clock edge. rd_ptr increments, and o_data shows the next entry after the edge.
- Pointers are $clog2(FIFO_DEPTH)+1 bits wide. The low bits index storage and the MSB is the wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
  - o_count = wr_ptr - rd_ptr, computed modulo 2^(ptr width).
- Simultaneous push and pop, when neither empty nor full: both occur and the count is unchanged.
- Push while full: impossible, because o_ready = 0. A same-cycle pop does not open a slot; there is no bypass.
- Pop while empty: impossible, because o_valid = 0. Empty-to-output bypass is not supported.
- i_flush has priority over push and pop in the same cycle. Pointers and count go to 0, and storage contents are left unchanged.
- Reset (i_rst_n low, at any time, including mid-transfer):
  - pointers = 0 and storage = 0
  - o_valid = 0, o_ready = 1, o_empty = 1, o_full = 0, o_count = 0, o_data = 0
- Producer rule: once i_valid is raised, the producer holds i_valid and i_data until the push. The FIFO does not depend on this rule for correctness.
- Non-synthesis checks, disabled under RTL_SYN:
  - fatal on X on i_valid, i_ready or i_flush
  - fatal on X on i_data during a push
  - fatal if o_count exceeds FIFO_DEPTH

## Timing
- Write latency: data pushed at edge N gives o_valid = 1 and o_data = that data from edge N onward (visible in cycle N+1).
- Throughput: one push and one pop per cycle, sustained.
- o_ready, o_valid, o_full, o_empty and o_count are decoded only from registered pointers. None of them depends combinationally on i_valid or i_ready.
- Flush asserted at edge N: o_valid = 0 and o_ready = 1 after edge N. A push requested at edge N is dropped.
- Reset assertion takes effect without a clock edge. After deassertion, the first push can occur on the first rising edge.

## Structure
- Shared package (fifo_pkg) holds:
  - the function computing pointer width from depth
  - the local constants PTR_W and CNT_W derivation
- Sub-module fifo_ptr_ctr:
  - one instance each for the write and read pointers
  - ports: clock, async reset, flush and increment
  - output: the PTR_W-bit pointer with wrap bit
- Storage: a flop array inside fifo_sync_vr with per-entry write enable, asynchronously reset to 0.
- Elaboration-time fatal if FIFO_DEPTH is not a power of two or is less than 2.

## Test plan
- Fill and drain (DEPTH=4): push 0x11, 0x22, 0x33, 0x44 with i_ready = 0.
  - Required: o_full = 1, o_ready = 0, o_count = 4.
  - Then hold i_ready = 1: o_data reads 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then o_empty = 1.
- Wrap-around: repeat 10 push-then-pop pairs with payload i.
  - Required: every pop returns i, and o_count stays within 0..1.
- Steady streaming: with count = 2, push and pop every cycle for 20 cycles with payload 0x100+i.
  - Required: count constant at 2, output order exact, no bubbles.
- Full with simultaneous pop: at count = 4, hold i_valid = 1 and i_ready = 1.
  - Required: the push is refused that cycle, count drops to 3, and the push is accepted on the next cycle.
- Flush priority: at count = 3, assert i_flush together with i_valid and i_ready.
  - Required: after the edge, o_count = 0, o_valid = 0, and the pushed word is lost.
- Async reset mid-stream: drop i_rst_n between clock edges at count = 2.
  - Required: o_valid = 0, o_ready = 1 and o_data = 0 immediately.
  - After release, push 0xAB: it appears on o_data one edge later.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: pointer/count width derivation and
// depth validation.
package fifo_pkg;

    // Pointer carries one extra wrap bit above the storage index.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return ptr_width(depth);
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Wrapping FIFO pointer with a wrap bit in the MSB; flush has priority over
// increment.
module fifo_ptr_ctr #(
    parameter int unsigned PTR_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;

    always_comb begin
        w_ptr_next = r_ptr;
        if (i_flush) begin
            w_ptr_next = '0;
        end else if (i_inc) begin
            w_ptr_next = r_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_sync_vr.sv
// First-word-fall-through synchronous FIFO with valid/ready on both sides;
// all status outputs decode from registered pointers only.
module fifo_sync_vr
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_flush,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [DATA_WIDTH-1:0]            i_data,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic [cnt_width(FIFO_DEPTH)-1:0] o_count,
    output logic                             o_full,
    output logic                             o_empty
);

    localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);
    localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);
    localparam int unsigned AW    = PTR_W - 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_depth
        $fatal(1, "fifo_sync_vr: FIFO_DEPTH must be a power of two and at least 2");
    end

    logic [PTR_W-1:0]      w_wr_ptr;
    logic [PTR_W-1:0]      w_rd_ptr;
    logic [AW-1:0]         w_wr_idx;
    logic [AW-1:0]         w_rd_idx;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [FIFO_DEPTH-1:0] w_we;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    assign w_wr_idx = w_wr_ptr[AW-1:0];
    assign w_rd_idx = w_rd_ptr[AW-1:0];
    assign w_empty  = (w_wr_ptr == w_rd_ptr);
    assign w_full   = (w_wr_idx == w_rd_idx) && (w_wr_ptr[AW] != w_rd_ptr[AW]);

    // No full-with-pop bypass: a push is gated only by the registered full flag.
    assign w_push = i_valid && !w_full && !i_flush;
    assign w_pop  = i_ready && !w_empty && !i_flush;

    fifo_ptr_ctr #(
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_inc   (w_push),
        .o_ptr   (w_wr_ptr)
    );

    fifo_ptr_ctr #(
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_inc   (w_pop),
        .o_ptr   (w_rd_ptr)
    );

    always_comb begin
        w_we = '0;
        if (w_push) begin
            w_we[w_wr_idx] = 1'b1;
        end
    end

    // Flush leaves storage untouched; only reset clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (w_we[i]) begin
                    r_mem[i] <= i_data;
                end
            end
        end
    end

    assign o_data  = r_mem[w_rd_idx];
    assign o_count = w_wr_ptr - w_rd_ptr;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_ready = !w_full;
    assign o_valid = !w_empty;

`ifndef RTL_SYN
    a_ctrl_known : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !$isunknown({i_valid, i_ready, i_flush}))
        else $fatal(1, "fifo_sync_vr: X on i_valid/i_ready/i_flush");

    a_data_known : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (i_valid && o_ready) |-> !$isunknown(i_data))
        else $fatal(1, "fifo_sync_vr: X on i_data during push");

    a_count_range : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_count <= DEPTH_CNT)
        else $fatal(1, "fifo_sync_vr: o_count exceeds FIFO_DEPTH");
`endif

endmodule

// File: tb/tb_fifo_sync_vr.sv
// Self-checking bench for fifo_sync_vr: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_fifo_sync_vr;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_flush;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic [2:0]    o_count;
    logic          o_full;
    logic          o_empty;

    fifo_sync_vr #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_count (o_count),
        .o_full  (o_full),
        .o_empty (o_empty)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: the FIFO is just an ordered list of at most DEPTH words.
    logic [DW-1:0] model_q [$];
    bit            m_push;
    bit            m_pop;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            model_q.delete();
        end else if (i_flush) begin
            model_q.delete();
        end else begin
            m_push = i_valid && (model_q.size() < DEPTH);
            m_pop  = i_ready && (model_q.size() > 0);
            if (m_pop) void'(model_q.pop_front());
            if (m_push) model_q.push_back(i_data);
        end
    end

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            chk("m_count", DW'(o_count), DW'(model_q.size()));
            chk("m_valid", DW'(o_valid), DW'(model_q.size() > 0));
            chk("m_ready", DW'(o_ready), DW'(model_q.size() < DEPTH));
            chk("m_full", DW'(o_full), DW'(model_q.size() == DEPTH));
            chk("m_empty", DW'(o_empty), DW'(model_q.size() == 0));
            if (model_q.size() > 0) chk("m_data", o_data, model_q[0]);
        end
    end

    // Inputs change 1 time unit after the rising edge; returns just after the next edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        i_valid = v;
        i_data  = d;
        i_ready = r;
        i_flush = f;
        @(posedge i_clk);
        #1;
    endtask

    logic [DW-1:0] fill_vals [4];

    initial begin
        fill_vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_flush = 1'b0;
        i_data  = '0;
        #1;
        chk("rst_valid", DW'(o_valid), 0);
        chk("rst_ready", DW'(o_ready), 1);
        chk("rst_empty", DW'(o_empty), 1);
        chk("rst_full", DW'(o_full), 0);
        chk("rst_count", DW'(o_count), 0);
        chk("rst_data", o_data, 0);
        #11 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Fill then drain
        for (int k = 0; k < 4; k++) step(1'b1, fill_vals[k], 1'b0, 1'b0);
        chk("fill_full", DW'(o_full), 1);
        chk("fill_ready", DW'(o_ready), 0);
        chk("fill_count", DW'(o_count), 4);
        for (int k = 0; k < 4; k++) begin
            chk("drain_data", o_data, fill_vals[k]);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("drain_empty", DW'(o_empty), 1);

        // Wrap-around with push/pop pairs
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0);
            chk("wrap_count1", DW'(o_count), 1);
            chk("wrap_data", o_data, DW'(i));
            step(1'b0, '0, 1'b1, 1'b0);
            chk("wrap_count0", DW'(o_count), 0);
        end

        // Steady streaming at occupancy 2
        step(1'b1, 32'h100, 1'b0, 1'b0);
        step(1'b1, 32'h101, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("stream_data", o_data, 32'h100 + DW'(i));
            step(1'b1, 32'h102 + DW'(i), 1'b1, 1'b0);
            chk("stream_count", DW'(o_count), 2);
            chk("stream_valid", DW'(o_valid), 1);
        end

        // Full with simultaneous pop: push refused, accepted next cycle
        step(1'b1, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h201, 1'b0, 1'b0);
        chk("full_count4", DW'(o_count), 4);
        step(1'b1, 32'h202, 1'b1, 1'b0);
        chk("full_pop_count", DW'(o_count), 3);
        chk("full_pop_head", o_data, 32'h115);
        step(1'b1, 32'h202, 1'b1, 1'b0);
        chk("full_next_count", DW'(o_count), 3);
        chk("full_next_head", o_data, 32'h200);

        // Flush beats push and pop
        step(1'b1, 32'h300, 1'b1, 1'b1);
        chk("flush_count", DW'(o_count), 0);
        chk("flush_valid", DW'(o_valid), 0);
        chk("flush_ready", DW'(o_ready), 1);
        step(1'b1, 32'h301, 1'b0, 1'b0);
        chk("flush_lost", o_data, 32'h301);
        chk("flush_cnt1", DW'(o_count), 1);

        // Async reset between edges
        step(1'b1, 32'h302, 1'b0, 1'b0);
        chk("arst_pre_count", DW'(o_count), 2);
        i_valid = 1'b0;
        #3 i_rst_n = 1'b0;
        #1;
        chk("arst_valid", DW'(o_valid), 0);
        chk("arst_ready", DW'(o_ready), 1);
        chk("arst_data", o_data, 0);
        chk("arst_count", DW'(o_count), 0);
        #2 i_rst_n = 1'b1;
        step(1'b1, 32'hAB, 1'b0, 1'b0);
        chk("arst_push_data", o_data, 32'hAB);
        chk("arst_push_valid", DW'(o_valid), 1);
        step(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0);
        end
        step(1'b0, '0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
